// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, optional
// hardwired-zero register 0, optional write-to-read bypass and a per-register
// busy scoreboard that drives the decode stall.
module regfile_sb #(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned NREG     = 32,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1,
   parameter int unsigned AW       = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic            we,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic            flush,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic            stall,
   output logic [AW:0]     busy_cnt
);

   logic [XLEN-1:0] rf_q [NREG];
   logic [XLEN-1:0] rf_d [NREG];
   logic [NREG-1:0] busy_q, busy_d;
   logic [AW:0]     cnt_q, cnt_d;

   logic [AW-1:0]   raddr [2];
   logic [XLEN-1:0] rdata [2];
   logic            rbusy [2];

   // Addresses above NREG-1 exist only when NREG is not a power of two.
   function automatic logic in_range(input logic [AW-1:0] a);
      return 32'(a) < NREG;
   endfunction

   // Register 0 is architecturally constant when ZERO_REG is set.
   function automatic logic is_zero(input logic [AW-1:0] a);
      return ZERO_REG && (a == '0);
   endfunction

   logic wr_ok;
   assign wr_ok = we && in_range(wr_addr) && !is_zero(wr_addr);

   // Next register-file contents: a single write per cycle.
   always_comb begin
      rf_d = rf_q;
      if (wr_ok) rf_d[wr_addr] = wr_data;
   end

   // Scoreboard next state: flush beats issue, issue beats writeback.
   always_comb begin
      busy_d = busy_q;
      cnt_d  = '0;
      for (int r = 0; r < int'(NREG); r++) begin
         if (flush) begin
            busy_d[r] = 1'b0;
         end else if (issue_valid && issue_rd == AW'(r)) begin
            busy_d[r] = 1'b1;
         end else if (we && wr_addr == AW'(r)) begin
            busy_d[r] = 1'b0;
         end
         if (ZERO_REG && r == 0) busy_d[r] = 1'b0;
         cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
      end
   end

   // State update; every entry is reset so reads never return x.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < int'(NREG); r++) rf_q[r] <= '0;
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         rf_q   <= rf_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign raddr[0] = rs1_addr;
   assign raddr[1] = rs2_addr;

   // Read ports: out-of-range and zero register read 0; writeback may bypass.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata[p] = '0;
         rbusy[p] = 1'b0;
         if (in_range(raddr[p]) && !is_zero(raddr[p])) begin
            if (BYPASS && we && wr_addr == raddr[p]) begin
               rdata[p] = wr_data;
            end else begin
               rdata[p] = rf_q[raddr[p]];
               rbusy[p] = busy_q[raddr[p]];
            end
         end
      end
   end

   assign rs1_data = rdata[0];
   assign rs2_data = rdata[1];
   assign rs1_busy = rbusy[0];
   assign rs2_busy = rbusy[1];
   assign stall    = rbusy[0] | rbusy[1];
   assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: four configurations share one stimulus stream and are
// checked every cycle against a behavioural model, plus literal spot checks.
module tb_regfile_sb;

   localparam int NI = 4;
   // Configurations: default, no bypass, NREG=24, no zero register.
   int cn [NI] = '{32, 32, 24, 32};
   bit cb [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};
   bit cz [NI] = '{1'b1, 1'b1, 1'b1, 1'b0};

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rs1_addr, rs2_addr, wr_addr, issue_rd;
   logic        we, issue_valid, flush;
   logic [63:0] wr_data;

   logic [63:0] o_d1 [NI];
   logic [63:0] o_d2 [NI];
   logic        o_b1 [NI];
   logic        o_b2 [NI];
   logic        o_st [NI];
   logic [5:0]  o_cnt [NI];

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   regfile_sb #(.XLEN(64), .NREG(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) u0 (
      .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(o_d1[0]), .rs2_data(o_d2[0]), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
      .rs1_busy(o_b1[0]), .rs2_busy(o_b2[0]), .stall(o_st[0]), .busy_cnt(o_cnt[0]));

   regfile_sb #(.XLEN(64), .NREG(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(o_d1[1]), .rs2_data(o_d2[1]), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
      .rs1_busy(o_b1[1]), .rs2_busy(o_b2[1]), .stall(o_st[1]), .busy_cnt(o_cnt[1]));

   regfile_sb #(.XLEN(64), .NREG(24), .ZERO_REG(1'b1), .BYPASS(1'b1)) u2 (
      .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(o_d1[2]), .rs2_data(o_d2[2]), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
      .rs1_busy(o_b1[2]), .rs2_busy(o_b2[2]), .stall(o_st[2]), .busy_cnt(o_cnt[2]));

   regfile_sb #(.XLEN(64), .NREG(32), .ZERO_REG(1'b0), .BYPASS(1'b1)) u3 (
      .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(o_d1[3]), .rs2_data(o_d2[3]), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
      .rs1_busy(o_b1[3]), .rs2_busy(o_b2[3]), .stall(o_st[3]), .busy_cnt(o_cnt[3]));

   // ---------------- behavioural model ----------------
   logic [63:0] m_rf   [NI][32];
   bit          m_busy [NI][32];

   initial begin
      for (int i = 0; i < NI; i++)
         for (int r = 0; r < 32; r++) begin
            m_rf[i][r] = '0;
            m_busy[i][r] = 1'b0;
         end
   end

   function automatic bool_ok(input int i, input logic [4:0] a);
      return (int'(a) < cn[i]) && !(cz[i] && a == 5'd0);
   endfunction

   function automatic logic [63:0] m_read(input int i, input logic [4:0] a);
      if (!bool_ok(i, a)) return 64'd0;
      if (cb[i] && we && wr_addr == a) return wr_data;
      return m_rf[i][a];
   endfunction

   function automatic logic m_busy_out(input int i, input logic [4:0] a);
      if (!bool_ok(i, a)) return 1'b0;
      if (cb[i] && we && wr_addr == a) return 1'b0;
      return m_busy[i][a];
   endfunction

   function automatic int m_count(input int i);
      int c = 0;
      for (int r = 0; r < 32; r++) if (m_busy[i][r]) c++;
      return c;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < NI; i++) begin
         if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
               m_rf[i][r] = '0;
               m_busy[i][r] = 1'b0;
            end
         end else begin
            if (we && bool_ok(i, wr_addr)) m_rf[i][wr_addr] = wr_data;
            if (flush) begin
               for (int r = 0; r < 32; r++) m_busy[i][r] = 1'b0;
            end else begin
               if (we && bool_ok(i, wr_addr)) m_busy[i][wr_addr] = 1'b0;
               if (issue_valid && bool_ok(i, issue_rd)) m_busy[i][issue_rd] = 1'b1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of all instances against the model.
   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         logic eb1, eb2;
         eb1 = m_busy_out(i, rs1_addr);
         eb2 = m_busy_out(i, rs2_addr);
         chk($sformatf("u%0d_rs1_data", i), o_d1[i], m_read(i, rs1_addr));
         chk($sformatf("u%0d_rs2_data", i), o_d2[i], m_read(i, rs2_addr));
         chk($sformatf("u%0d_rs1_busy", i), 64'(o_b1[i]), 64'(eb1));
         chk($sformatf("u%0d_rs2_busy", i), 64'(o_b2[i]), 64'(eb2));
         chk($sformatf("u%0d_stall", i), 64'(o_st[i]), 64'(eb1 | eb2));
         chk($sformatf("u%0d_busy_cnt", i), 64'(o_cnt[i]), 64'(m_count(i)));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0;
      issue_valid = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      rs1_addr = '0; rs2_addr = '0; wr_addr = '0; issue_rd = '0;
      wr_data = '0;
      idle();
      step();
      step();
      #1;
      chk("reset_rs1_data", o_d1[0], 64'd0);
      chk("reset_busy_cnt", 64'(o_cnt[0]), 64'd0);
      rst_n = 1'b1;

      // Write 0xAA to reg 5, then async reset mid-cycle.
      step();
      we = 1'b1; wr_addr = 5'd5; wr_data = 64'hAA; rs1_addr = 5'd5;
      step();
      idle();
      #1 chk("write5_read", o_d1[1], 64'hAA);
      #1 rst_n = 1'b0;
      #1 chk("async_reset_data_u0", o_d1[0], 64'd0);
      chk("async_reset_data_u3", o_d1[3], 64'd0);
      step();
      rst_n = 1'b1;

      // Write and issue to reg 0.
      we = 1'b1; wr_addr = 5'd0; wr_data = 64'hFFFF; rs1_addr = 5'd0;
      issue_valid = 1'b1; issue_rd = 5'd0;
      step();
      idle();
      #1;
      chk("zero_reg_data", o_d1[0], 64'd0);
      chk("zero_reg_cnt", 64'(o_cnt[0]), 64'd0);
      chk("nozero_reg_data", o_d1[3], 64'hFFFF);
      chk("nozero_reg_cnt", 64'(o_cnt[3]), 64'd1);

      // Write/read bypass on reg 7.
      we = 1'b1; wr_addr = 5'd7; wr_data = 64'h1234_5678_9ABC_DEF0; rs2_addr = 5'd7;
      #1;
      chk("bypass_same_cycle", o_d2[0], 64'h1234_5678_9ABC_DEF0);
      chk("nobypass_old_value", o_d2[1], 64'd0);
      step();
      idle();
      #1 chk("nobypass_next_cycle", o_d2[1], 64'h1234_5678_9ABC_DEF0);

      // Scoreboard lifecycle on reg 3.
      issue_valid = 1'b1; issue_rd = 5'd3; rs1_addr = 5'd3;
      step();
      idle();
      #1;
      chk("issue3_busy", 64'(o_b1[0]), 64'd1);
      chk("issue3_stall", 64'(o_st[0]), 64'd1);
      chk("issue3_cnt", 64'(o_cnt[0]), 64'd1);
      we = 1'b1; wr_addr = 5'd3; wr_data = 64'h33;
      #1;
      chk("wb3_bypass_busy", 64'(o_b1[0]), 64'd0);
      chk("wb3_nobypass_busy", 64'(o_b1[1]), 64'd1);
      step();
      idle();
      #1 chk("wb3_cnt", 64'(o_cnt[0]), 64'd0);

      // Issue and writeback to reg 9 together, then issue with flush.
      issue_valid = 1'b1; issue_rd = 5'd9; we = 1'b1; wr_addr = 5'd9; wr_data = 64'h99;
      rs2_addr = 5'd9;
      step();
      idle();
      #1;
      chk("issue_wins_busy", 64'(o_b2[0]), 64'd1);
      chk("issue_wins_cnt", 64'(o_cnt[0]), 64'd1);
      issue_valid = 1'b1; issue_rd = 5'd9; flush = 1'b1;
      step();
      idle();
      #1;
      chk("flush_wins_busy", 64'(o_b2[0]), 64'd0);
      chk("flush_wins_cnt", 64'(o_cnt[0]), 64'd0);

      // Capacity: issue 1..31 back to back, then flush.
      for (int r = 1; r < 32; r++) begin
         issue_valid = 1'b1; issue_rd = 5'(r); rs1_addr = 5'(r); rs2_addr = 5'(32 - r);
         step();
      end
      idle();
      #1;
      chk("full_cnt_u0", 64'(o_cnt[0]), 64'd31);
      chk("full_cnt_u2", 64'(o_cnt[2]), 64'd23);
      chk("full_cnt_u3", 64'(o_cnt[3]), 64'd31);
      flush = 1'b1;
      step();
      idle();
      #1 chk("flush_cnt", 64'(o_cnt[0]), 64'd0);

      // Out-of-range address on the 24-entry instance.
      we = 1'b1; wr_addr = 5'd30; wr_data = 64'hDEAD; issue_valid = 1'b1; issue_rd = 5'd30;
      rs1_addr = 5'd30;
      #1;
      chk("oor_data_same", o_d1[2], 64'd0);
      chk("oor_busy_same", 64'(o_b1[2]), 64'd0);
      step();
      idle();
      #1;
      chk("oor_data_next", o_d1[2], 64'd0);
      chk("oor_cnt", 64'(o_cnt[2]), 64'd0);
      chk("inrange_data_u0", o_d1[0], 64'hDEAD);

      // Mixed traffic patterns.
      for (int i = 0; i < 10; i++) begin
         we = (i % 3) != 2;
         wr_addr = 5'((i * 7 + 2) % 32);
         wr_data = {32'hC0DE_0000 + 32'(i), 32'hFACE_0000 ^ 32'(i * 17)};
         issue_valid = (i % 2) == 0;
         issue_rd = 5'((i * 5 + 1) % 32);
         rs1_addr = wr_addr;
         rs2_addr = 5'((i * 5 + 1) % 32);
         step();
      end
      idle();
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's 64-bit, 32-entry register file, sitting between decode and writeback in the pipelined core.
- Two combinational read ports and one clocked write port, with:
  - an optional hardwired-zero register 0;
  - optional write-to-read bypass;
  - a per-register busy scoreboard (set on issue, cleared on writeback, flushable) that drives the decode stall.

Parameters:
- XLEN, 64: register width in bits.
- NREG, 32: number of registers; 2..64, power of two not required.
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes and is never busy.
- BYPASS, 1: 1 = same-cycle writeback data is forwarded to the read ports and masks the busy bit.
- AW, $clog2(NREG): address width; not to be overridden.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  XLEN  read port 1 data, combinational.
- rs2_data  out  XLEN  read port 2 data, combinational.
- we  in  1  writeback enable.
- wr_addr  in  AW  writeback address.
- wr_data  in  XLEN  writeback data.
- issue_valid  in  1  instruction issued this cycle with destination issue_rd.
- issue_rd  in  AW  destination register of the issued instruction.
- flush  in  1  clears all busy bits (pipeline flush).
- rs1_busy  out  1  rs1 has an outstanding producer.
- rs2_busy  out  1  rs2 has an outstanding producer.
- stall  out  1  rs1_busy | rs2_busy.
- busy_cnt  out  AW+1  number of set busy bits, registered.

Behaviour:
- Reset (rst_n=0, async, no clock needed):
  - all registers 0, all busy bits 0, busy_cnt 0.
  - rs*_data, rs*_busy and stall therefore read 0.
  - On release, the first write takes effect at the first rising edge with rst_n=1.
- Write path:
  - at a rising edge with we=1 and wr_addr<NREG, RF[wr_addr] <= wr_data.
  - ignored if ZERO_REG=1 and wr_addr=0.
  - wr_addr>=NREG: no write.
- Read path, combinational, evaluated per port in priority order:
  - addr>=NREG → 0.
  - ZERO_REG=1 and addr=0 → 0.
  - BYPASS=1, we=1 and wr_addr=addr → wr_data.
  - else RF[addr].
  - BYPASS=0: reads return the old value in the write cycle and the new value from the next cycle.
- Scoreboard, per register r, next value at each rising edge in priority order:
  - flush=1 → 0.
  - issue_valid=1 and issue_rd=r → 1.
  - we=1 and wr_addr=r → 0.
  - else hold.
  - Issue wins over a same-cycle writeback to the same register (new producer supersedes the retiring one).
  - Register 0 (ZERO_REG=1) and addresses >=NREG never set.
  - Issue with flush in the same cycle: flush wins, bit stays 0.
- Busy outputs (combinational):
  - rsN_busy = busy[rsN_addr], forced 0 if ZERO_REG=1 and rsN_addr=0, or if rsN_addr>=NREG.
  - With BYPASS=1, also forced 0 when we=1 and wr_addr=rsN_addr.
- busy_cnt:
  - registered population count of the next busy vector, so it matches busy bits the cycle after each edge.
  - Never exceeds NREG-ZERO_REG.
- No internal x propagation: every RF entry is reset, so reads are always defined.

Test Plan:
- Reset/zero-register: rst_n=0 mid-run with RF[5]=0xAA → rs1_data(5)=0 immediately, without a clock edge. Then write 0xFFFF to reg 0 → rs1_data(0)=0, busy_cnt=0.
- Write then read: we=1, wr_addr=7, wr_data=0x1234_5678_9ABC_DEF0.
  - BYPASS=1: rs2_data(7) equals that value in the same cycle.
  - BYPASS=0: rs2_data(7) shows the old value (0), and the new value the next cycle.
- Scoreboard lifecycle:
  - Issue rd=3 → rs1_busy(3)=1, stall=1, busy_cnt=1 next cycle.
  - Writeback to reg 3: with BYPASS=1, rs1_busy=0 in that cycle and busy_cnt=0 after the edge.
- Simultaneous events:
  - issue_rd=9 and wr_addr=9 in the same cycle → busy[9]=1 afterwards.
  - issue_rd=9 with flush=1 → busy[9]=0, busy_cnt=0.
- Capacity/flush: issue rd=1..31 back-to-back → busy_cnt=31 (NREG=32, ZERO_REG=1). Then flush=1 → all busy 0, busy_cnt=0 one cycle later.
- Non-power-of-two (NREG=24, AW=5): write to addr 30 ignored; read addr 30 → data 0, busy 0; issue rd=30 leaves busy_cnt unchanged.
